// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline stall/flush sequencer for the 5-stage core.
// It detects load-use hazards that forwarding cannot cover, holds the pipeline
// for a multi-cycle multiply/divide occupying E, and squashes the fetched
// instruction on a taken branch.
// Optional feature: define HAZ_STALL_CNT_EN to add a free-running 32-bit
// StallCount output that counts cycles in which the PC is held.
// MULDIV_LAT is the total E-stage occupancy of a mult/div op (legal 2..16).

module hazard_stall_controller #(
  parameter int MULDIV_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsAddr_D,
  input  logic [4:0] RtAddr_D,
  input  logic [4:0] RegDstAddr_E,
  input  logic       MemRead_E,
  input  logic       MulDivStart_E,
  input  logic       BranchTaken_D,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulDivDone,
  output logic       Busy
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0] StallCount
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } stateT;

  // The start cycle counts as the first occupancy cycle, so MD_BUSY lasts
  // MULDIV_LAT-1 cycles, which means the counter starts at MULDIV_LAT-2.
  localparam logic [3:0] CntLoad = 4'(MULDIV_LAT - 2);

  stateT      state;
  stateT      nextState;
  logic [3:0] cnt;
  logic [3:0] nextCnt;
  logic       loadUse;

  // A load whose destination feeds either source of D cannot be forwarded in time.
  // Register 0 is hardwired, so a load targeting it never causes a hazard.
  always_comb begin
    loadUse = MemRead_E && (RegDstAddr_E != 5'd0) &&
              ((RegDstAddr_E == RsAddr_D) || (RegDstAddr_E == RtAddr_D));
  end

  // State and down-counter register. Reset aborts any mult/div sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Next-state and output decode. Priority in RUN is mult/div start, then load-use, then branch.
  always_comb begin
    nextState  = state;
    nextCnt    = cnt;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    MulDivDone = 1'b0;
    Busy       = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (MulDivStart_E) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            FlushM    = 1'b1;
            nextState = MD_BUSY;
            nextCnt   = CntLoad;
          end else if (loadUse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end else if (BranchTaken_D) begin
            FlushD = 1'b1;
          end
        end
        MD_BUSY: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          Busy   = 1'b1;
          if (cnt != 4'd0) begin
            nextCnt = cnt - 4'd1;
          end else begin
            MulDivDone = 1'b1;
            nextState  = RUN;
          end
        end
        default: begin
          nextState = RUN;
          nextCnt   = 4'd0;
        end
      endcase
    end
  end

`ifdef HAZ_STALL_CNT_EN
  // Count every clock edge on which the PC is held; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= 32'd0;
    end else if (StallF) begin
      StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule
